axitoaudio_i2s_tx: RTL

- Downstream stage of the AXI-to-audio register block: consumes stereo sample frames over a valid/ready handshake and serialises them onto an I2S bus (BCLK, LRCLK, SDATA).
- Generates the bit clock and word clock internally from the system clock by parameterised division.
- Buffers frames in a small FIFO to absorb AXI write jitter, and reports underruns to software status.

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_frame_fifo.sv | 60 ++++++
 rtl/axitoaudio_i2s_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and frame type for the I2S transmit path
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEF = 24;
    localparam int SLOT_WIDTH_DEF   = 32;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    typedef struct packed {
        logic [SAMPLE_WIDTH_DEF-1:0] left;
        logic [SAMPLE_WIDTH_DEF-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - synchronous show-ahead FIFO of stereo frames
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  stereo_frame_t i_push_data,
    input  logic          i_pop,
    output stereo_frame_t o_pop_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    stereo_frame_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_level == (AW+1)'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/axitoaudio_i2s_tx.sv
// rtl/axitoaudio_i2s_tx.sv - buffered stereo frame serialiser driving an I2S bus
module axitoaudio_i2s_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int SLOT_WIDTH    = SLOT_WIDTH_DEF,
    parameter int BCLK_HALF_DIV = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_WIDTH-1:0]       s_left,
    input  logic [SAMPLE_WIDTH-1:0]       s_right,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam int K_W        = $clog2(FRAME_BITS);
    localparam int PAD        = SLOT_WIDTH - SAMPLE_WIDTH;

    logic [DIV_W-1:0]      r_div_cnt;
    logic [K_W-1:0]        r_bit_idx;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_underrun;
    logic [15:0]           r_underrun_count;

    logic                  w_div_tc;
    logic                  w_fall;
    logic                  w_frame_start;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_lr_next;
    stereo_frame_t         w_push_frame;
    stereo_frame_t         w_head;
    logic [SLOT_WIDTH-1:0] w_left_slot;
    logic [SLOT_WIDTH-1:0] w_right_slot;
    logic [FRAME_BITS-1:0] w_load;

    assign s_ready       = !reset && !w_full;
    assign w_push        = s_valid && s_ready;
    assign w_push_frame  = '{left: s_left, right: s_right};

    assign w_div_tc      = (r_div_cnt == DIV_W'(BCLK_HALF_DIV - 1));
    assign w_fall        = enable && w_div_tc && r_bclk;
    assign w_frame_start = w_fall && (r_bit_idx == '0);

    // Word select leads each slot's MSB by one bit clock.
    assign w_lr_next     = (r_bit_idx >= K_W'(SLOT_WIDTH - 1)) &&
                           (r_bit_idx <= K_W'(FRAME_BITS - 2));

    assign w_left_slot   = SLOT_WIDTH'(w_head.left) << PAD;
    assign w_right_slot  = SLOT_WIDTH'(w_head.right) << PAD;
    assign w_load        = w_empty ? '0 : {w_left_slot, w_right_slot};

    audio_frame_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clock),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_frame),
        .i_pop       (w_frame_start),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_tc ? '0 : r_div_cnt + 1'b1;
            if (w_div_tc) begin
                r_bclk <= !r_bclk;
            end
            if (w_fall) begin
                r_lrclk <= w_lr_next;
                if (w_frame_start) begin
                    r_sdata <= w_load[FRAME_BITS-1];
                    r_shift <= w_load << 1;
                end else begin
                    r_sdata <= r_shift[FRAME_BITS-1];
                    r_shift <= r_shift << 1;
                end
                r_bit_idx <= (r_bit_idx == K_W'(FRAME_BITS - 1)) ? '0 : r_bit_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_underrun <= w_frame_start && w_empty;
            if (w_frame_start && w_empty && (r_underrun_count != UNDERRUN_MAX)) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

    assign bclk           = r_bclk;
    assign lrclk          = r_lrclk;
    assign sdata          = r_sdata;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule
